ddram_burst_responder: RTL and testbench

- Responder (memory side) of the 64-bit Avalon-style DDRAM burst interface that Main drives as initiator: burstcount, word address, rd, we, din, byte-enable, busy, dout, dout_ready.
- Backs the interface with an on-chip 64-bit block RAM.
- Injects programmable read latency and periodic busy back-pressure.
- Used as the DDR stand-in for core-level simulation and for SDRAM-less bring-up builds in the clk_sys domain.

---
 rtl/ddram_pkg.sv | 20 ++
 rtl/ddram_resp_mem.sv | 39 +++
 rtl/ddram_burst_responder.sv | 166 ++++++++++++++++
 tb/tb_ddram_burst_responder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddram_pkg.sv
`default_nettype none
// ==========================================================================
// ddram_pkg - shared types and constants for the DDRAM burst responder. rev 1.0
// ==========================================================================
package ddram_pkg;
  localparam int DDR_BYTES = 8;

  typedef logic [63:0]          ddr_word_t;
  typedef logic [DDR_BYTES-1:0] ddr_be_t;
  typedef logic [28:0]          ddr_addr_t;
  typedef logic [7:0]           ddr_burst_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_RD_BURST = 2'd3
  } ddr_state_t;
endpackage
`default_nettype wire

// File: rtl/ddram_resp_mem.sv
`default_nettype none
// ==========================================================================
// ddram_resp_mem - 64-bit RAM, byte-enabled write port, registered read port. rev 1.0
// ==========================================================================
module ddram_resp_mem
  import ddram_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk_sys,
  input  logic                 RESET,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  ddr_word_t            wdata_i,
  input  ddr_be_t              be_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output ddr_word_t            rdata_o
);
  ddr_word_t mem_q [2**ADDR_BITS];
  ddr_word_t rdata_q;

  always_ff @(posedge clk_sys) begin
    if (we_i) begin
      for (int i = 0; i < DDR_BYTES; i++) begin
        if (be_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Read register only loads on re_i so the last beat stays on the bus.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule
`default_nettype wire

// File: rtl/ddram_burst_responder.sv
`default_nettype none
// ==========================================================================
// ddram_burst_responder - on-chip RAM responder for the 64-bit DDRAM burst bus. rev 1.0
// ==========================================================================
module ddram_burst_responder
  import ddram_pkg::*;
#(
  parameter int ADDR_BITS    = 12,
  parameter int READ_LATENCY = 4,
  parameter int BUSY_PERIOD  = 0
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic [7:0]  ddram_burstcnt,
  input  logic [28:0] ddram_addr,
  input  logic        ddram_rd,
  input  logic        ddram_we,
  input  logic [63:0] ddram_din,
  input  logic [7:0]  ddram_be,
  output logic        ddram_busy,
  output logic [63:0] ddram_dout,
  output logic        ddram_dout_ready,
  output logic        err,
  output logic [15:0] rd_bursts,
  output logic [15:0] wr_bursts
);
  localparam logic [3:0] c_LAT_INIT = 4'(READ_LATENCY - 2);

  ddr_state_t             state_q;
  logic [ADDR_BITS-1:0]   addr_q;
  ddr_burst_t             remain_q;
  logic [3:0]             lat_q;
  logic                   rd_busy_q;
  logic                   dout_ready_q;
  logic                   err_q;
  logic [15:0]            rd_bursts_q;
  logic [15:0]            wr_bursts_q;

  logic                   w_thr_hit;
  logic                   w_busy;
  logic                   w_cmd_bad;
  logic [ADDR_BITS-1:0]   w_cmd_addr;
  logic                   w_mem_we;
  logic [ADDR_BITS-1:0]   w_mem_waddr;
  logic                   w_mem_re;
  ddr_word_t              w_rdata;
  logic                   w_unused_addr;

  generate
    if (BUSY_PERIOD != 0) begin : g_throttle
      localparam logic [15:0] c_THR_LAST = 16'(BUSY_PERIOD - 1);
      logic [15:0] thr_q;
      always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET)                    thr_q <= '0;
        else if (thr_q == c_THR_LAST) thr_q <= '0;
        else                          thr_q <= thr_q + 16'd1;
      end
      assign w_thr_hit = (thr_q == c_THR_LAST);
    end else begin : g_no_throttle
      assign w_thr_hit = 1'b0;
    end
  endgenerate

  // rd_busy_q is set exactly while in RD_WAIT/RD_BURST, so throttle only shows elsewhere.
  assign w_busy        = rd_busy_q | w_thr_hit;
  assign w_cmd_bad     = (ddram_rd && ddram_we) || (ddram_burstcnt == 8'd0);
  assign w_cmd_addr    = ddram_addr[ADDR_BITS-1:0];
  assign w_unused_addr = ^ddram_addr[28:ADDR_BITS];

  assign w_mem_we    = !w_busy && ddram_we &&
                       ((state_q == ST_IDLE && !ddram_rd && ddram_burstcnt != 8'd0) ||
                        state_q == ST_WR_BURST);
  assign w_mem_waddr = (state_q == ST_IDLE) ? w_cmd_addr : addr_q;
  // Fetch one word ahead so each beat's data is in the read register on time.
  assign w_mem_re    = (state_q == ST_RD_WAIT && lat_q == 4'd0) ||
                       (state_q == ST_RD_BURST && remain_q != 8'd1);

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      lat_q        <= '0;
      rd_busy_q    <= 1'b0;
      dout_ready_q <= 1'b0;
      err_q        <= 1'b0;
      rd_bursts_q  <= '0;
      wr_bursts_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!w_busy && (ddram_rd || ddram_we)) begin
            if (w_cmd_bad) begin
              err_q <= 1'b1;
            end else if (ddram_rd) begin
              addr_q      <= w_cmd_addr;
              remain_q    <= ddram_burstcnt;
              lat_q       <= c_LAT_INIT;
              rd_busy_q   <= 1'b1;
              rd_bursts_q <= rd_bursts_q + 16'd1;
              state_q     <= ST_RD_WAIT;
            end else if (ddram_burstcnt == 8'd1) begin
              wr_bursts_q <= wr_bursts_q + 16'd1;
            end else begin
              addr_q   <= w_cmd_addr + ADDR_BITS'(1);
              remain_q <= ddram_burstcnt - 8'd1;
              state_q  <= ST_WR_BURST;
            end
          end
        end
        ST_WR_BURST: begin
          if (!w_busy && ddram_rd) err_q <= 1'b1;
          if (!w_busy && ddram_we) begin
            addr_q   <= addr_q + ADDR_BITS'(1);
            remain_q <= remain_q - 8'd1;
            if (remain_q == 8'd1) begin
              wr_bursts_q <= wr_bursts_q + 16'd1;
              state_q     <= ST_IDLE;
            end
          end
        end
        ST_RD_WAIT: begin
          if (lat_q == 4'd0) begin
            addr_q       <= addr_q + ADDR_BITS'(1);
            dout_ready_q <= 1'b1;
            state_q      <= ST_RD_BURST;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        ST_RD_BURST: begin
          if (remain_q == 8'd1) begin
            dout_ready_q <= 1'b0;
            rd_busy_q    <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            addr_q   <= addr_q + ADDR_BITS'(1);
            remain_q <= remain_q - 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ddram_resp_mem #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .we_i    (w_mem_we),
    .waddr_i (w_mem_waddr),
    .wdata_i (ddram_din),
    .be_i    (ddram_be),
    .re_i    (w_mem_re),
    .raddr_i (addr_q),
    .rdata_o (w_rdata)
  );

  assign ddram_busy       = w_busy;
  assign ddram_dout       = w_rdata;
  assign ddram_dout_ready = dout_ready_q;
  assign err              = err_q;
  assign rd_bursts        = rd_bursts_q;
  assign wr_bursts        = wr_bursts_q;
endmodule
`default_nettype wire

// File: tb/tb_ddram_burst_responder.sv
`default_nettype none
// ==========================================================================
// tb_ddram_burst_responder - directed table plus random traffic on two configurations. rev 1.0
// ==========================================================================
module tb_ddram_burst_responder;
  localparam int LAT0 = 4;
  localparam int LAT1 = 3;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic [7:0]  bcnt  [2];
  logic [28:0] addr  [2];
  logic        rd    [2];
  logic        we    [2];
  logic [63:0] din   [2];
  logic [7:0]  be    [2];
  logic        busy  [2];
  logic [63:0] dout  [2];
  logic        dvld  [2];
  logic        err   [2];
  logic [15:0] rdb   [2];
  logic [15:0] wrb   [2];

  always #5 clk = ~clk;

  // Instance 0: default geometry, no throttle. Instance 1: 16 words, latency 3, busy every 3rd cycle.
  ddram_burst_responder #(.ADDR_BITS(12), .READ_LATENCY(LAT0), .BUSY_PERIOD(0)) u_dut0 (
    .clk_sys(clk), .RESET(rst[0]), .ddram_burstcnt(bcnt[0]), .ddram_addr(addr[0]),
    .ddram_rd(rd[0]), .ddram_we(we[0]), .ddram_din(din[0]), .ddram_be(be[0]),
    .ddram_busy(busy[0]), .ddram_dout(dout[0]), .ddram_dout_ready(dvld[0]),
    .err(err[0]), .rd_bursts(rdb[0]), .wr_bursts(wrb[0]));

  ddram_burst_responder #(.ADDR_BITS(4), .READ_LATENCY(LAT1), .BUSY_PERIOD(3)) u_dut1 (
    .clk_sys(clk), .RESET(rst[1]), .ddram_burstcnt(bcnt[1]), .ddram_addr(addr[1]),
    .ddram_rd(rd[1]), .ddram_we(we[1]), .ddram_din(din[1]), .ddram_be(be[1]),
    .ddram_busy(busy[1]), .ddram_dout(dout[1]), .ddram_dout_ready(dvld[1]),
    .err(err[1]), .rd_bursts(rdb[1]), .wr_bursts(wrb[1]));

  int          errors = 0;
  int          checks = 0;
  logic [63:0] mdl [2][4096];
  int          exp_rd [2];
  int          exp_wr [2];
  logic [63:0] beats [$];
  bit          bhist [$];

  typedef struct {
    bit          wr;
    logic [28:0] a;
    int          n;
    logic [63:0] data;
    logic [7:0]  bev;
    logic [63:0] exp_first;
    logic [63:0] exp_last;
    int          exp_rdb;
    int          exp_wrb;
  } vec_t;

  function automatic int depth(int d);
    return (d == 0) ? 4096 : 16;
  endfunction

  function automatic int lat(int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic set_idle(int d);
    rd[d]   = 1'b0;
    we[d]   = 1'b0;
    addr[d] = 29'($urandom);
    bcnt[d] = 8'($urandom);
    din[d]  = {$urandom, $urandom};
    be[d]   = 8'($urandom);
  endtask

  task automatic idle(int d, int cycles);
    repeat (cycles) begin
      @(negedge clk);
      set_idle(d);
    end
  endtask

  task automatic chk_reset(int d);
    chk("rst_busy",  64'(busy[d]), 64'd0);
    chk("rst_ready", 64'(dvld[d]), 64'd0);
    chk("rst_dout",  dout[d], 64'd0);
    chk("rst_err",   64'(err[d]), 64'd0);
    chk("rst_rdb",   64'(rdb[d]), 64'd0);
    chk("rst_wrb",   64'(wrb[d]), 64'd0);
  endtask

  task automatic chk_counts(int d);
    chk("rd_bursts", 64'(rdb[d]), 64'(exp_rd[d] % 65536));
    chk("wr_bursts", 64'(wrb[d]), 64'(exp_wr[d] % 65536));
  endtask

  // A beat is accepted at the next rising edge iff busy is low while it is presented.
  task automatic do_write(int d, logic [28:0] a, int n, logic [63:0] base, logic [7:0] bev, bit gaps);
    int k = 0;
    int guard = 0;
    int w;
    bhist.delete();
    while (k < n) begin
      @(negedge clk);
      guard++;
      if (guard > 400) begin
        chk("write_timeout", 64'(k), 64'(n));
        return;
      end
      rd[d]   = 1'b0;
      addr[d] = (k == 0) ? a : 29'($urandom);
      bcnt[d] = (k == 0) ? 8'(n) : 8'($urandom);
      if (gaps && k > 0 && $urandom_range(0, 3) == 0) begin
        we[d]  = 1'b0;
        din[d] = {$urandom, $urandom};
      end else begin
        we[d]  = 1'b1;
        din[d] = base + 64'(k);
        be[d]  = bev;
        bhist.push_back(busy[d]);
        if (!busy[d]) begin
          w = (int'(a) + k) & (depth(d) - 1);
          for (int i = 0; i < 8; i++)
            if (bev[i]) mdl[d][w][8*i +: 8] = din[d][8*i +: 8];
          k++;
        end
      end
    end
    exp_wr[d]++;
  endtask

  // abort_beat >= 0 asserts reset during that (0-based) beat and checks the immediate effect.
  task automatic do_read(int d, logic [28:0] a, int n, int abort_beat);
    int guard = 0;
    int L = lat(d);
    int w;
    beats.delete();
    do begin
      @(negedge clk);
      rd[d] = 1'b1; we[d] = 1'b0; addr[d] = a; bcnt[d] = 8'(n);
      guard++;
    end while (busy[d] && guard < 400);
    if (busy[d]) begin
      chk("read_accept_timeout", 64'(busy[d]), 64'd0);
      return;
    end
    exp_rd[d]++;
    for (int c = 1; c <= L + n; c++) begin
      @(negedge clk);
      if (c == 1) set_idle(d);
      chk("rd_ready", 64'(dvld[d]), 64'(c >= L && c < L + n));
      if (c < L + n)   chk("rd_busy", 64'(busy[d]), 64'd1);
      else if (d == 0) chk("rd_busy_end", 64'(busy[d]), 64'd0);
      if (dvld[d]) beats.push_back(dout[d]);
      if (c >= L && c < L + n) begin
        w = (int'(a) + c - L) & (depth(d) - 1);
        chk("rd_data", dout[d], mdl[d][w]);
      end
      if (c == L + n) begin
        chk("rd_hold", dout[d], mdl[d][(int'(a) + n - 1) & (depth(d) - 1)]);
        chk("rd_nbeats", 64'(beats.size()), 64'(n));
      end
      if (abort_beat >= 0 && c == L + abort_beat) begin
        rst[d] = 1'b1;
        #1;
        chk_reset(d);
        exp_rd[d] = 0;
        exp_wr[d] = 0;
        @(negedge clk);
        rst[d] = 1'b0;
        set_idle(d);
        return;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [5];
    logic [28:0] ra;
    int          rn;
    int          bad;
    int          ones;

    tbl[0] = '{1'b1, 29'h10, 1, 64'h1122334455667788, 8'hFF, 64'h0, 64'h0, 0, 1};
    tbl[1] = '{1'b0, 29'h10, 1, 64'h0, 8'h00, 64'h1122334455667788, 64'h1122334455667788, 1, 1};
    tbl[2] = '{1'b1, 29'h20, 8, 64'h0, 8'hFF, 64'h0, 64'h0, 1, 2};
    tbl[3] = '{1'b1, 29'h23, 1, 64'hFF, 8'h01, 64'h0, 64'h0, 1, 3};
    tbl[4] = '{1'b0, 29'h20, 8, 64'h0, 8'h00, 64'h0, 64'h7, 2, 3};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      set_idle(d);
      exp_rd[d] = 0;
      exp_wr[d] = 0;
    end
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].wr) begin
        do_write(0, tbl[i].a, tbl[i].n, tbl[i].data, tbl[i].bev, 1'b0);
      end else begin
        do_read(0, tbl[i].a, tbl[i].n, -1);
        chk("tbl_first", (beats.size() > 0) ? beats[0] : 64'hX, tbl[i].exp_first);
        chk("tbl_last",  (beats.size() > 0) ? beats[beats.size()-1] : 64'hX, tbl[i].exp_last);
      end
      idle(0, 1);
      chk("tbl_rdb", 64'(rdb[0]), 64'(tbl[i].exp_rdb));
      chk("tbl_wrb", 64'(wrb[0]), 64'(tbl[i].exp_wrb));
    end
    chk("be_merge_beat3", (beats.size() > 3) ? beats[3] : 64'hX, 64'hFF);

    // Protocol errors: rd+we together, read with zero length, write with zero length.
    @(negedge clk);
    rd[0] = 1'b1; we[0] = 1'b1; addr[0] = 29'h10; bcnt[0] = 8'd1; din[0] = 64'hDEAD; be[0] = 8'hFF;
    @(negedge clk); set_idle(0);
    chk("err_rdwe", 64'(err[0]), 64'd1);
    @(negedge clk);
    chk("err_rdwe_once", 64'(err[0]), 64'd0);
    rd[0] = 1'b1; addr[0] = 29'h10; bcnt[0] = 8'd0;
    @(negedge clk); set_idle(0);
    chk("err_bc0", 64'(err[0]), 64'd1);
    chk("err_bc0_idle", 64'(busy[0]), 64'd0);
    @(negedge clk);
    chk("err_bc0_once", 64'(err[0]), 64'd0);
    chk("err_still_idle", 64'(busy[0]), 64'd0);
    we[0] = 1'b1; addr[0] = 29'h10; bcnt[0] = 8'd0; din[0] = 64'hBEEF; be[0] = 8'hFF;
    @(negedge clk); set_idle(0);
    chk("err_wr_bc0", 64'(err[0]), 64'd1);
    @(negedge clk);
    chk_counts(0);
    do_read(0, 29'h10, 1, -1);
    chk("err_ram_kept", (beats.size() > 0) ? beats[0] : 64'hX, 64'h1122334455667788);
    idle(0, 1);
    chk_counts(0);

    // Reset during beat 3 of a burst-8 read, then a normal single read.
    do_read(0, 29'h20, 8, 2);
    idle(0, 1);
    do_read(0, 29'h10, 1, -1);
    chk("post_rst_data", (beats.size() > 0) ? beats[0] : 64'hX, 64'h1122334455667788);
    idle(0, 1);
    chk("post_rst_rdb", 64'(rdb[0]), 64'd1);
    chk("post_rst_wrb", 64'(wrb[0]), 64'd0);

    // Throttle on instance 1: burst 6 with we held high.
    do_write(1, 29'h4, 6, 64'h600, 8'hFF, 1'b0);
    bad = 0;
    ones = 0;
    for (int i = 0; i < bhist.size(); i++) ones += int'(bhist[i]);
    for (int i = 0; i + 2 < bhist.size(); i++)
      if (int'(bhist[i]) + int'(bhist[i+1]) + int'(bhist[i+2]) != 1) bad++;
    idle(1, 1);
    chk("thr_period", 64'(bad), 64'd0);
    chk("thr_pulses", 64'(ones >= 2), 64'd1);
    chk("thr_wrb", 64'(wrb[1]), 64'd1);
    do_read(1, 29'h4, 6, -1);
    chk("thr_beat5", (beats.size() > 5) ? beats[5] : 64'hX, 64'h605);

    // Wrap on a 16-word RAM.
    do_write(1, 29'hE, 4, 64'hA0, 8'hFF, 1'b0);
    do_read(1, 29'h10, 1, -1);
    chk("wrap_third_beat", (beats.size() > 0) ? beats[0] : 64'hX, 64'hA2);
    do_read(1, 29'hE, 4, -1);
    chk("wrap_read_last", (beats.size() > 3) ? beats[3] : 64'hX, 64'hA3);
    idle(1, 1);
    chk_counts(1);

    // Random traffic, instance 0, in a pre-written window with random upper address bits.
    for (int i = 0; i < 16; i++)
      do_write(0, 29'h100 + 29'(8 * i), 8, {$urandom, $urandom}, 8'hFF, 1'b0);
    for (int i = 0; i < 60; i++) begin
      ra = (29'h100 + 29'($urandom_range(0, 'h78))) | (29'($urandom) & 29'h1FFF_F000);
      rn = $urandom_range(1, 8);
      if ($urandom_range(0, 1) == 1) do_write(0, ra, rn, {$urandom, $urandom}, 8'($urandom), 1'b1);
      else                           do_read(0, ra, rn, -1);
      idle(0, $urandom_range(0, 2));
    end
    idle(0, 1);
    chk_counts(0);

    // Random traffic, instance 1, any address, bursts longer than the RAM.
    do_write(1, 29'h0, 16, {$urandom, $urandom}, 8'hFF, 1'b0);
    for (int i = 0; i < 40; i++) begin
      ra = 29'($urandom);
      rn = $urandom_range(1, 20);
      if ($urandom_range(0, 1) == 1) do_write(1, ra, rn, {$urandom, $urandom}, 8'($urandom), 1'b1);
      else                           do_read(1, ra, rn, -1);
      idle(1, $urandom_range(0, 2));
    end
    idle(1, 1);
    chk_counts(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
